// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus for mem_access_unit.
//   Pipeline side : Req, Ready, Wr, Size, Uns, Addr, WData, RData, Done, Err
//   Memory side   : DataAddr, DataIn, DataOut, DMemW, DMemR
// slave  = the access unit; master = pipeline plus memory environment.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              Req;
    logic              Ready;
    logic              Wr;
    logic [1:0]        Size;
    logic              Uns;
    logic [31:0]       Addr;
    logic [31:0]       WData;
    logic [31:0]       RData;
    logic              Done;
    logic              Err;
    logic [ADDR_W-1:0] DataAddr;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic              DMemW;
    logic              DMemR;

    modport slave (
        input  Req, Wr, Size, Uns, Addr, WData, DataOut,
        output Ready, RData, Done, Err, DataAddr, DataIn, DMemW, DMemR
    );

    modport master (
        output Req, Wr, Size, Uns, Addr, WData, DataOut,
        input  Ready, RData, Done, Err, DataAddr, DataIn, DMemW, DMemR
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller in front of a word-addressed data memory.
// Word stores write directly, byte/half stores do read-modify-write, loads are
// lane-extracted and sign/zero-extended. Misaligned or out-of-range requests
// complete with Err and never touch memory.
// Ports: CLK, RST_N (synchronous, active-low), bus (mem_access_unit_if.slave).
module mem_access_unit #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP,
        S_ERR
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int unsigned HI_SHIFT = ADDR_W + 2;

    state_e            state_q, state_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              req_err_c;
    logic [31:0]       merged_c;
    logic [31:0]       lane_c;
    logic [31:0]       shifted_c;
    logic [4:0]        bsh_c;
    logic [4:0]        hsh_c;

    // Request legality: reserved size, misalignment, or address beyond memory.
    always_comb begin
        req_err_c = 1'b0;
        if (bus.Size == 2'b11)                              req_err_c = 1'b1;
        if (bus.Size == SZ_HALF && bus.Addr[0])             req_err_c = 1'b1;
        if (bus.Size == SZ_WORD && bus.Addr[1:0] != 2'b00)  req_err_c = 1'b1;
        if ((bus.Addr >> HI_SHIFT) != 32'd0)                req_err_c = 1'b1;
    end

    // Store word: replace the addressed lane of the captured word.
    always_comb begin
        bsh_c = {off_q, 3'b000};
        hsh_c = {off_q[1], 4'b0000};
        case (size_q)
            SZ_BYTE: merged_c = (word_q & ~(32'h0000_00FF << bsh_c))
                              | ({24'd0, wdata_q[7:0]} << bsh_c);
            SZ_HALF: merged_c = (word_q & ~(32'h0000_FFFF << hsh_c))
                              | ({16'd0, wdata_q[15:0]} << hsh_c);
            default: merged_c = wdata_q;
        endcase
    end

    // Load result: shift the addressed lane down and extend it.
    always_comb begin
        shifted_c = bus.DataOut >> bsh_c;
        case (size_q)
            SZ_BYTE: lane_c = uns_q ? {24'd0, shifted_c[7:0]}
                                    : {{24{shifted_c[7]}}, shifted_c[7:0]};
            SZ_HALF: lane_c = uns_q ? {16'd0, shifted_c[15:0]}
                                    : {{16{shifted_c[15]}}, shifted_c[15:0]};
            default: lane_c = bus.DataOut;
        endcase
    end

    // State and latched-field registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            waddr_q <= '0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Req) begin
                    wr_d    = bus.Wr;
                    size_d  = bus.Size;
                    uns_d   = bus.Uns;
                    off_d   = bus.Addr[1:0];
                    wdata_d = bus.WData;
                    if (req_err_c) begin
                        state_d = S_ERR;
                    end else begin
                        // Only updated for legal requests so DataAddr holds through ERR.
                        waddr_d = bus.Addr[ADDR_W+1:2];
                        state_d = (bus.Wr && bus.Size == SZ_WORD) ? S_WR : S_RD;
                    end
                end
            end
            S_RD: begin
                word_d = bus.DataOut;
                if (wr_q) begin
                    state_d = S_WR;
                end else begin
                    rdata_d = lane_c;
                    state_d = S_RESP;
                end
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from registered state and latched fields only.
    assign bus.Ready    = (state_q == S_IDLE);
    assign bus.Done     = (state_q == S_RESP) || (state_q == S_ERR);
    assign bus.Err      = (state_q == S_ERR);
    assign bus.RData    = rdata_q;
    assign bus.DMemR    = (state_q == S_RD);
    // Gated by RST_N so a write pending in the reset cycle is dropped.
    assign bus.DMemW    = (state_q == S_WR) && RST_N;
    assign bus.DataAddr = waddr_q;
    assign bus.DataIn   = merged_c;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 32-word behavioural data memory.
module tb_mem_access_unit;
    localparam int unsigned ADDR_W = 5;

    logic CLK = 1'b0;
    logic RST_N;
    logic mem_clr;
    int   checks = 0;
    int   errors = 0;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Data memory: combinational read, write on rising edge.
    logic [31:0] mem [32];
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
        end else if (bus.DMemW) begin
            mem[bus.DataAddr] <= bus.DataIn;
        end
    end
    assign bus.DataOut = mem[bus.DataAddr];

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        chk_wr;
        logic [4:0]  waddr;
        logic [31:0] wword;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request from IDLE and follow it to Done (bounded).
    task automatic run_req(input vec_t v, input int idx);
        int          lat;
        int          nw;
        logic        saw_r;
        logic        got_done;
        logic        got_err;
        logic [31:0] got_rd;
        logic [31:0] wd;
        logic [4:0]  wa;
        lat = 0; nw = 0; saw_r = 1'b0; got_done = 1'b0; got_err = 1'b0;
        got_rd = 32'd0; wd = 32'd0; wa = 5'd0;
        check($sformatf("v%0d ready", idx), 32'(bus.Ready), 32'd1);
        @(negedge CLK);
        bus.Req = 1'b1; bus.Wr = v.wr; bus.Size = v.size; bus.Uns = v.uns;
        bus.Addr = v.addr; bus.WData = v.wdata;
        while (!got_done && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
            bus.Req = 1'b0;
            if (bus.DMemR) saw_r = 1'b1;
            if (bus.DMemW) begin nw++; wd = bus.DataIn; wa = bus.DataAddr; end
            if (bus.Done) begin got_done = 1'b1; got_err = bus.Err; got_rd = bus.RData; end
        end
        check($sformatf("v%0d latency", idx), 32'(got_done ? lat : 99), 32'(v.lat));
        check($sformatf("v%0d err", idx), 32'(got_err), 32'(v.err));
        if (v.chk_rd) check($sformatf("v%0d rdata", idx), got_rd, v.rdata);
        if (v.err) check($sformatf("v%0d mem strobes", idx), 32'(saw_r || nw != 0), 32'd0);
        if (v.chk_wr) begin
            check($sformatf("v%0d write count", idx), 32'(nw), 32'd1);
            check($sformatf("v%0d write addr", idx), 32'(wa), 32'(v.waddr));
            check($sformatf("v%0d write data", idx), wd, v.wword);
        end
        @(posedge CLK); #1;
        check($sformatf("v%0d done single", idx), 32'(bus.Done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic        ready_log [6];
    logic        done_log  [6];
    logic [31:0] rd_log    [6];
    logic [31:0] win_log   [6];

    initial begin
        //            wr  size   uns addr       wdata         lat err chk_rd rdata          chk_wr waddr wword
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, 2, 1'b0, 1'b0, 32'h0,         1'b1, 5'd2,  32'h11223344};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        2, 1'b0, 1'b1, 32'h11223344,  1'b0, 5'd0,  32'h0};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h09, 32'h000000AB, 3, 1'b0, 1'b0, 32'h0,         1'b1, 5'd2,  32'h1122AB44};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h09, 32'h0,        2, 1'b0, 1'b1, 32'hFFFFFFAB,  1'b0, 5'd0,  32'h0};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h09, 32'h0,        2, 1'b0, 1'b1, 32'h000000AB,  1'b0, 5'd0,  32'h0};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0A, 32'h0,        2, 1'b0, 1'b1, 32'h00001122,  1'b0, 5'd0,  32'h0};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h0A, 32'h00008001, 3, 1'b0, 1'b0, 32'h0,         1'b1, 5'd2,  32'h8001AB44};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h0A, 32'h0,        2, 1'b0, 1'b1, 32'hFFFF8001,  1'b0, 5'd0,  32'h0};
        vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h0A, 32'h0,        2, 1'b0, 1'b1, 32'h00008001,  1'b0, 5'd0,  32'h0};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0A, 32'h0,        1, 1'b1, 1'b0, 32'h0,         1'b0, 5'd0,  32'h0};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h03, 32'h0,        1, 1'b1, 1'b0, 32'h0,         1'b0, 5'd0,  32'h0};
        vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        1, 1'b1, 1'b0, 32'h0,         1'b0, 5'd0,  32'h0};
        vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h08, 32'h0,        1, 1'b1, 1'b0, 32'h0,         1'b0, 5'd0,  32'h0};
        vecs[13] = '{1'b0, 2'b00, 1'b0, 32'h08, 32'h0,        2, 1'b0, 1'b1, 32'h00000044,  1'b0, 5'd0,  32'h0};
        vecs[14] = '{1'b1, 2'b00, 1'b0, 32'h0B, 32'h123456FF, 3, 1'b0, 1'b0, 32'h0,         1'b1, 5'd2,  32'hFF01AB44};
        vecs[15] = '{1'b0, 2'b00, 1'b0, 32'h0B, 32'h0,        2, 1'b0, 1'b1, 32'hFFFFFFFF,  1'b0, 5'd0,  32'h0};
        vecs[16] = '{1'b1, 2'b10, 1'b0, 32'h7C, 32'hDEADBEEF, 2, 1'b0, 1'b0, 32'h0,         1'b1, 5'd31, 32'hDEADBEEF};
        vecs[17] = '{1'b0, 2'b10, 1'b0, 32'h7C, 32'h0,        2, 1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 5'd0,  32'h0};
        vecs[18] = '{1'b0, 2'b01, 1'b0, 32'h7E, 32'h0,        2, 1'b0, 1'b1, 32'hFFFFDEAD,  1'b0, 5'd0,  32'h0};
        vecs[19] = '{1'b1, 2'b10, 1'b0, 32'h0E, 32'h0,        1, 1'b1, 1'b0, 32'h0,         1'b0, 5'd0,  32'h0};
        vecs[20] = '{1'b0, 2'b01, 1'b1, 32'h7C, 32'h0,        2, 1'b0, 1'b1, 32'h0000BEEF,  1'b0, 5'd0,  32'h0};
        vecs[21] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, 2, 1'b0, 1'b0, 32'h0,         1'b1, 5'd4,  32'hCAFEF00D};
        vecs[22] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        2, 1'b0, 1'b1, 32'hCAFEF00D,  1'b0, 5'd0,  32'h0};

        RST_N = 1'b0; mem_clr = 1'b1;
        bus.Req = 1'b0; bus.Wr = 1'b0; bus.Size = 2'b00; bus.Uns = 1'b0;
        bus.Addr = 32'd0; bus.WData = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1; mem_clr = 1'b0;

        check("reset ready", 32'(bus.Ready), 32'd1);
        check("reset done",  32'(bus.Done),  32'd0);
        check("reset err",   32'(bus.Err),   32'd0);
        check("reset rdata", bus.RData,      32'd0);
        check("reset dmemw", 32'(bus.DMemW), 32'd0);
        check("reset dmemr", 32'(bus.DMemR), 32'd0);

        for (int i = 0; i < 22; i++) run_req(vecs[i], i);

        // Req held through a busy SB, inputs switched to LW after the accept.
        check("hold ready0", 32'(bus.Ready), 32'd1);
        @(negedge CLK);
        bus.Req = 1'b1; bus.Wr = 1'b1; bus.Size = 2'b00; bus.Uns = 1'b0;
        bus.Addr = 32'h14; bus.WData = 32'h00000077;
        for (int s = 0; s < 6; s++) begin
            @(posedge CLK); #1;
            ready_log[s] = bus.Ready;
            done_log[s]  = bus.Done;
            rd_log[s]    = bus.RData;
            win_log[s]   = bus.DataIn;
            if (s == 0) begin bus.Wr = 1'b0; bus.Size = 2'b10; bus.WData = 32'd0; end
            if (s == 4) bus.Req = 1'b0;
        end
        check("hold ready", {26'd0, ready_log[0], ready_log[1], ready_log[2],
                             ready_log[3], ready_log[4], ready_log[5]}, 32'b000100);
        check("hold done",  {26'd0, done_log[0], done_log[1], done_log[2],
                             done_log[3], done_log[4], done_log[5]}, 32'b001001);
        check("hold sb data", win_log[1], 32'h00000077);
        check("hold lw rdata", rd_log[5], 32'h00000077);
        @(posedge CLK); #1;
        check("hold idle ready", 32'(bus.Ready), 32'd1);
        check("hold idle done",  32'(bus.Done),  32'd0);

        // Reset asserted during the WR cycle of an SB.
        @(negedge CLK);
        bus.Req = 1'b1; bus.Wr = 1'b1; bus.Size = 2'b00; bus.Uns = 1'b0;
        bus.Addr = 32'h11; bus.WData = 32'h00000055;
        @(posedge CLK); #1;
        bus.Req = 1'b0;
        check("abort rd strobe", 32'(bus.DMemR), 32'd1);
        @(posedge CLK); #1;
        check("abort wr before reset", 32'(bus.DMemW), 32'd1);
        RST_N = 1'b0;
        #1;
        check("abort dmemw suppressed", 32'(bus.DMemW), 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        check("abort ready",  32'(bus.Ready), 32'd1);
        check("abort done",   32'(bus.Done),  32'd0);
        check("abort err",    32'(bus.Err),   32'd0);
        check("abort rdata",  bus.RData,      32'd0);
        check("abort mem word", mem[4],       32'hCAFEF00D);
        @(posedge CLK); #1;
        check("abort no late done", 32'(bus.Done), 32'd0);
        run_req(vecs[22], 22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
